mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 22 ++
 rtl/mem_access_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_access_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared types and constants for the data-bus access controller
package mem_access_ctrl_pkg;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic FLUSH_ENABLE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_chan_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding data-bus sequencer with pipeline stall/flush control
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        EXE_MemReq,
  input  logic        EXE_MemWr,
  input  logic [1:0]  EXE_MemSize,
  input  logic [31:0] EXE_MemAddr,
  input  logic [31:0] EXE_MemWData,
  input  logic [3:0]  EXE_MemWStrb,
  input  logic        Exception_Flush,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        EXE_Wr,
  output logic        MEM_Wr,
  output logic        MEM_Flush,
  output logic        WB_Flush,
  output logic [31:0] WB_RData,
  output logic        Mem_Busy
);

  mem_state_e  state_q, state_d;
  logic        cancel_q, cancel_d;
  mem_chan_t   chan_q, chan_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;

  mem_chan_t   exe_chan, chan_o;
  logic        flush, in_window, issue, in_reset;

  assign exe_chan  = '{wr: EXE_MemWr, size: EXE_MemSize, addr: EXE_MemAddr,
                       wdata: EXE_MemWData, wstrb: EXE_MemWStrb};
  assign flush     = (Exception_Flush == FLUSH_ENABLE);
  assign in_reset  = (rst == RST_ENABLE);
  // A new request may go out while idle, or in the very cycle the previous one completes.
  assign in_window = (state_q == ST_IDLE) || ((state_q == ST_DATA) && data_data_ok);
  assign issue     = in_window && EXE_MemReq && !flush;

  always_ff @(posedge clk) begin
    if (in_reset) begin
      state_q    <= ST_IDLE;
      cancel_q   <= 1'b0;
      chan_q     <= '0;
      wb_rdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cancel_q   <= cancel_d;
      chan_q     <= chan_d;
      wb_rdata_q <= wb_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cancel_d   = 1'b0;
    chan_d     = chan_q;
    wb_rdata_d = wb_rdata_q;
    if (issue) chan_d = exe_chan;
    case (state_q)
      ST_IDLE: begin
        if (issue) state_d = data_addr_ok ? ST_DATA : ST_ADDR;
      end
      ST_ADDR: begin
        // A flush seen while waiting for acceptance turns the eventual response into a discard.
        if (data_addr_ok) state_d = (cancel_q || flush) ? ST_DRAIN : ST_DATA;
        else              cancel_d = cancel_q || flush;
      end
      ST_DATA: begin
        if (data_data_ok) begin
          if (!chan_q.wr) wb_rdata_d = data_rdata;
          if (issue) state_d = data_addr_ok ? ST_DATA : ST_ADDR;
          else       state_d = ST_IDLE;
        end else if (flush) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (data_data_ok) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_req  = 1'b0;
    chan_o    = in_window ? exe_chan : chan_q;
    EXE_Wr    = 1'b1;
    MEM_Wr    = 1'b1;
    MEM_Flush = 1'b0;
    WB_Flush  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DATA: begin
        if (state_q == ST_DATA && !data_data_ok) begin
          EXE_Wr   = 1'b0;
          MEM_Wr   = 1'b0;
          WB_Flush = 1'b1;
        end else if (issue) begin
          data_req = 1'b1;
          if (!data_addr_ok) begin
            EXE_Wr    = 1'b0;
            MEM_Flush = 1'b1;
          end
        end
      end
      ST_ADDR: begin
        data_req = 1'b1;
        if (!data_addr_ok) begin
          EXE_Wr    = 1'b0;
          MEM_Flush = 1'b1;
        end
      end
      default: begin
        EXE_Wr    = 1'b0;
        MEM_Flush = 1'b1;
        WB_Flush  = 1'b1;
      end
    endcase
    if (flush) MEM_Flush = 1'b1;
    if (in_reset) begin
      data_req  = 1'b0;
      EXE_Wr    = 1'b1;
      MEM_Wr    = 1'b1;
      MEM_Flush = 1'b0;
      WB_Flush  = 1'b0;
    end
  end

  assign data_wr    = chan_o.wr;
  assign data_size  = chan_o.size;
  assign data_addr  = chan_o.addr;
  assign data_wdata = chan_o.wdata;
  assign data_wstrb = chan_o.wstrb;
  assign WB_RData   = wb_rdata_q;
  assign Mem_Busy   = !in_reset && (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - per-cycle vector table plus scoreboarded random-latency loads
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        EXE_MemReq, EXE_MemWr, Exception_Flush;
  logic [1:0]  EXE_MemSize;
  logic [31:0] EXE_MemAddr, EXE_MemWData;
  logic [3:0]  EXE_MemWStrb;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        EXE_Wr, MEM_Wr, MEM_Flush, WB_Flush, Mem_Busy;
  logic [31:0] WB_RData;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .EXE_MemReq(EXE_MemReq), .EXE_MemWr(EXE_MemWr), .EXE_MemSize(EXE_MemSize),
    .EXE_MemAddr(EXE_MemAddr), .EXE_MemWData(EXE_MemWData), .EXE_MemWStrb(EXE_MemWStrb),
    .Exception_Flush(Exception_Flush),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .EXE_Wr(EXE_Wr), .MEM_Wr(MEM_Wr), .MEM_Flush(MEM_Flush), .WB_Flush(WB_Flush),
    .WB_RData(WB_RData), .Mem_Busy(Mem_Busy)
  );

  typedef struct {
    logic        rst, req, wr, fl, aok, dok;
    logic [31:0] addr, rdata;
    logic        dreq, ewr, mwr, mfl, wfl, busy;
    logic [31:0] eaddr, wbr;
  } vec_t;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  logic [31:0] sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  localparam logic [31:0] B  = 32'hDEAD_BEEF, C1 = 32'hA5A5_0001, C2 = 32'hA5A5_0002;
  localparam logic [31:0] C3 = 32'hA5A5_0003, C4 = 32'hA5A5_0004, BAD = 32'hBAD0_BAD0;

  task automatic add(input logic rst_v, req, wr, fl, aok, dok, input logic [31:0] addr, rdata,
                     input logic dreq, ewr, mwr, mfl, wfl, busy, input logic [31:0] eaddr, wbr);
    vecs.push_back('{rst_v, req, wr, fl, aok, dok, addr, rdata,
                     dreq, ewr, mwr, mfl, wfl, busy, eaddr, wbr});
  endtask

  task automatic drive(input logic r, req, wr, fl, aok, dok, input logic [31:0] addr, rdata);
    rst = r; EXE_MemReq = req; EXE_MemWr = wr; Exception_Flush = fl;
    data_addr_ok = aok; data_data_ok = dok; EXE_MemAddr = addr; data_rdata = rdata;
    EXE_MemSize = 2'd2; EXE_MemWData = ~addr; EXE_MemWStrb = wr ? 4'hf : 4'h0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v.rst, v.req, v.wr, v.fl, v.aok, v.dok, v.addr, v.rdata);
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
    n_vec++;
    chk($sformatf("v%0d data_req", n_vec), {31'b0, data_req}, {31'b0, e.dreq});
    chk($sformatf("v%0d EXE_Wr", n_vec), {31'b0, EXE_Wr}, {31'b0, e.ewr});
    chk($sformatf("v%0d MEM_Wr", n_vec), {31'b0, MEM_Wr}, {31'b0, e.mwr});
    chk($sformatf("v%0d MEM_Flush", n_vec), {31'b0, MEM_Flush}, {31'b0, e.mfl});
    chk($sformatf("v%0d WB_Flush", n_vec), {31'b0, WB_Flush}, {31'b0, e.wfl});
    chk($sformatf("v%0d Mem_Busy", n_vec), {31'b0, Mem_Busy}, {31'b0, e.busy});
    chk($sformatf("v%0d WB_RData", n_vec), WB_RData, e.wbr);
    if (e.dreq) chk($sformatf("v%0d data_addr", n_vec), data_addr, e.eaddr);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] rdata, input int alat, input int dlat);
    int req_cycles = 0;
    sb_q.push_back(rdata);
    for (int c = 0; c <= alat; c++) begin
      @(negedge clk);
      drive(1, 1, 0, 0, c == alat, 0, addr, 32'h0);
      #2;
      if (data_req) req_cycles++;
      chk("seq data_addr", data_addr, addr);
    end
    for (int d = 0; d <= dlat; d++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, d == dlat, 32'h0, (d == dlat) ? rdata : BAD);
      #2;
      chk("seq WB_Flush", {31'b0, WB_Flush}, {31'b0, d != dlat});
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #2;
    n_vec++;
    chk("seq req_cycles", req_cycles, alat + 1);
    chk("seq WB_RData", WB_RData, sb_q.pop_front());
    chk("seq Mem_Busy", {31'b0, Mem_Busy}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    #2;
    n_vec++;
    chk("rst data_req", {31'b0, data_req}, 32'h0);
    chk("rst Mem_Busy", {31'b0, Mem_Busy}, 32'h0);
    chk("rst EXE_Wr", {31'b0, EXE_Wr}, 32'h1);

    add(0,1,0,0,1,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, 32'h0);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, 32'h0);
    // load, addr_ok and data_ok one cycle late
    add(1,1,0,0,0,0, 32'h8000_0010,32'h0,  1,0,1,1,0,0, 32'h8000_0010, 32'h0);
    add(1,1,0,0,1,0, 32'h0,32'h0,          1,1,1,0,0,1, 32'h8000_0010, 32'h0);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,0,0,0,1,1, 32'h0, 32'h0);
    add(1,0,0,0,0,1, 32'h0,B,              0,1,1,0,0,1, 32'h0, 32'h0);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, B);
    // store, immediate accept, data_ok after three stall cycles
    add(1,1,1,0,1,0, 32'h100,32'h0,        1,1,1,0,0,0, 32'h100, B);
    for (int i = 0; i < 3; i++)
      add(1,0,0,0,0,0, 32'h0,32'h0,        0,0,0,0,1,1, 32'h0, B);
    add(1,0,0,0,0,1, 32'h0,32'h1111_1111,  0,1,1,0,0,1, 32'h0, B);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, B);
    // back-to-back loads issued in the data_ok cycle
    add(1,1,0,0,1,0, 32'h200,32'h0,        1,1,1,0,0,0, 32'h200, B);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,0,0,0,1,1, 32'h0, B);
    add(1,1,0,0,1,1, 32'h204,C1,           1,1,1,0,0,1, 32'h204, B);
    add(1,1,0,0,0,1, 32'h208,C2,           1,0,1,1,0,1, 32'h208, C1);
    add(1,1,0,0,1,0, 32'h0,32'h0,          1,1,1,0,0,1, 32'h208, C2);
    add(1,0,0,0,0,1, 32'h0,C3,             0,1,1,0,0,1, 32'h0, C2);
    // flush blocks issue in IDLE; stray data_ok ignored
    add(1,1,0,1,1,1, 32'h2FC,BAD,          0,1,1,1,0,0, 32'h0, C3);
    // flush while waiting for addr_ok -> drain
    add(1,1,0,0,0,0, 32'h300,32'h0,        1,0,1,1,0,0, 32'h300, C3);
    add(1,1,0,1,0,1, 32'h0,BAD,            1,0,1,1,0,1, 32'h300, C3);
    add(1,0,0,0,0,0, 32'h0,32'h0,          1,0,1,1,0,1, 32'h300, C3);
    add(1,0,0,0,1,0, 32'h0,32'h0,          1,1,1,0,0,1, 32'h300, C3);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,0,1,1,1,1, 32'h0, C3);
    add(1,0,0,0,0,1, 32'h0,32'h1234_5678,  0,0,1,1,1,1, 32'h0, C3);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, C3);
    // flush in DATA without data_ok -> drain
    add(1,1,0,0,1,0, 32'h400,32'h0,        1,1,1,0,0,0, 32'h400, C3);
    add(1,0,0,1,0,0, 32'h0,32'h0,          0,0,0,1,1,1, 32'h0, C3);
    add(1,0,0,0,0,1, 32'h0,BAD,            0,0,1,1,1,1, 32'h0, C3);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, C3);
    // flush with data_ok in DATA: capture, no issue
    add(1,1,0,0,1,0, 32'h410,32'h0,        1,1,1,0,0,0, 32'h410, C3);
    add(1,1,0,1,1,1, 32'h414,C4,           0,1,1,1,0,1, 32'h0, C3);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, C4);
    // reset while in DATA
    add(1,1,0,0,1,0, 32'h500,32'h0,        1,1,1,0,0,0, 32'h500, C4);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,0,0,0,1,1, 32'h0, C4);
    add(0,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, C4);
    add(1,0,0,0,0,1, 32'h0,32'h77,         0,1,1,0,0,0, 32'h0, 32'h0);
    add(1,0,0,0,0,0, 32'h0,32'h0,          0,1,1,0,0,0, 32'h0, 32'h0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    for (int i = 0; i < 6; i++)
      do_load(32'h1000 + 32'(i) * 4, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
